// File: rtl/psram_rsp.sv
// psram_rsp: octal PSRAM responder with a 2**MEM_AW-byte array and four 8-bit mode registers.
// Define PSRAM_RSP_CHK_EN to build the sticky protocol checker driving err_o.
module psram_rsp #(
    parameter int unsigned MEM_AW = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  cfg_rcmd_i,
    input  logic [7:0]  cfg_wcmd_i,
    input  logic [7:0]  cfg_mrcmd_i,
    input  logic [7:0]  cfg_mwcmd_i,
    input  logic [7:0]  cfg_rlc_i,
    input  logic [7:0]  cfg_wlc_i,
    input  logic        psram_sck_i,
    input  logic        psram_ce_i,
    input  logic [7:0]  psram_io_in_i,
    input  logic        psram_dqs_in_i,
    output logic [7:0]  psram_io_out_o,
    output logic        psram_io_en_o,
    output logic        psram_dqs_out_o,
    output logic        psram_dqs_en_o,
    output logic [31:0] mr_o,
    output logic        err_o
);

    localparam int unsigned MEM_SZ = 2 ** MEM_AW;

    typedef enum logic [2:0] {
        IDLE, INST, ADDR, LATN, WDATA, RDATA, MWR, IGNR
    } state_e;

    logic              sck_q, sck_prev_q, ce_q, dqs_q;
    logic [7:0]        io_q;

    state_e            state_q, state_d;
    logic              armed_q, armed_d;
    logic              inst_got_q, inst_got_d;
    logic [7:0]        opcode_q, opcode_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [7:0]        lat_q, lat_d;
    logic              is_wr_q, is_wr_d;
    logic              is_mr_q, is_mr_d;
    logic              mwr_done_q, mwr_done_d;
    logic [3:0][7:0]   mr_q, mr_d;
    logic [7:0]        io_out_q, io_out_d;
    logic              io_en_q, io_en_d;
    logic              dqs_out_q, dqs_out_d;
    logic              dqs_en_q, dqs_en_d;

    logic [7:0]        mem [MEM_SZ];
    logic              mem_we_c;
    logic              edge_c, rise_c;
    logic [MEM_AW-1:0] rd_addr_c;
    logic [7:0]        rd_data_c;

    assign edge_c = sck_q ^ sck_prev_q;
    assign rise_c = sck_q & ~sck_prev_q;

    // On RDATA entry the current byte is fetched; inside RDATA each edge fetches the next one.
    assign rd_addr_c = (state_q == RDATA) ? addr_q + MEM_AW'(1) : addr_q;
    assign rd_data_c = is_mr_q ? mr_q[rd_addr_c[1:0]] : mem[rd_addr_c];

    always_comb begin
        state_d    = state_q;
        armed_d    = armed_q | ce_q;
        inst_got_d = inst_got_q;
        opcode_d   = opcode_q;
        addr_d     = addr_q;
        byte_cnt_d = byte_cnt_q;
        lat_d      = lat_q;
        is_wr_d    = is_wr_q;
        is_mr_d    = is_mr_q;
        mwr_done_d = mwr_done_q;
        mr_d       = mr_q;
        io_out_d   = io_out_q;
        dqs_out_d  = dqs_out_q;
        mem_we_c   = 1'b0;

        if (ce_q) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    // After reset a fresh ce high is needed before a new command is accepted.
                    if (armed_q) begin
                        state_d    = INST;
                        inst_got_d = 1'b0;
                    end
                end
                INST: begin
                    if (rise_c && !inst_got_q) begin
                        opcode_d   = io_q;
                        inst_got_d = 1'b1;
                    end else if (edge_c && inst_got_q) begin
                        state_d    = ADDR;
                        byte_cnt_d = 2'd0;
                    end
                end
                ADDR: begin
                    if (edge_c) begin
                        addr_d     = MEM_AW'({addr_q, io_q});
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            if (opcode_q == cfg_rcmd_i) begin
                                state_d = LATN;
                                lat_d   = cfg_rlc_i;
                                is_wr_d = 1'b0;
                                is_mr_d = 1'b0;
                            end else if (opcode_q == cfg_wcmd_i) begin
                                state_d = LATN;
                                lat_d   = cfg_wlc_i;
                                is_wr_d = 1'b1;
                                is_mr_d = 1'b0;
                            end else if (opcode_q == cfg_mrcmd_i) begin
                                state_d = LATN;
                                lat_d   = cfg_rlc_i;
                                is_wr_d = 1'b0;
                                is_mr_d = 1'b1;
                            end else if (opcode_q == cfg_mwcmd_i) begin
                                state_d    = MWR;
                                mwr_done_d = 1'b0;
                            end else begin
                                state_d = IGNR;
                            end
                        end
                    end
                end
                LATN: begin
                    if (rise_c) begin
                        if (lat_q == 8'd0) begin
                            if (is_wr_q) begin
                                state_d = WDATA;
                            end else begin
                                state_d   = RDATA;
                                io_out_d  = rd_data_c;
                                dqs_out_d = 1'b0;
                            end
                        end else begin
                            lat_d = lat_q - 8'd1;
                        end
                    end
                end
                WDATA: begin
                    if (edge_c) begin
                        mem_we_c = dqs_q;
                        addr_d   = addr_q + MEM_AW'(1);
                    end
                end
                RDATA: begin
                    if (edge_c) begin
                        addr_d    = addr_q + MEM_AW'(1);
                        io_out_d  = rd_data_c;
                        dqs_out_d = ~dqs_out_q;
                    end
                end
                MWR: begin
                    if (edge_c && !mwr_done_q) begin
                        mr_d[addr_q[1:0]] = io_q;
                        mwr_done_d        = 1'b1;
                    end
                end
                IGNR: begin
                    state_d = IGNR;
                end
            endcase
        end

        io_en_d  = (state_d == RDATA);
        dqs_en_d = (state_d == RDATA);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sck_q      <= 1'b0;
            sck_prev_q <= 1'b0;
            ce_q       <= 1'b0;
            io_q       <= 8'd0;
            dqs_q      <= 1'b0;
            state_q    <= IDLE;
            armed_q    <= 1'b0;
            inst_got_q <= 1'b0;
            opcode_q   <= 8'd0;
            addr_q     <= '0;
            byte_cnt_q <= 2'd0;
            lat_q      <= 8'd0;
            is_wr_q    <= 1'b0;
            is_mr_q    <= 1'b0;
            mwr_done_q <= 1'b0;
            mr_q       <= '0;
            io_out_q   <= 8'd0;
            io_en_q    <= 1'b0;
            dqs_out_q  <= 1'b0;
            dqs_en_q   <= 1'b0;
        end else begin
            sck_q      <= psram_sck_i;
            sck_prev_q <= sck_q;
            ce_q       <= psram_ce_i;
            io_q       <= psram_io_in_i;
            dqs_q      <= psram_dqs_in_i;
            state_q    <= state_d;
            armed_q    <= armed_d;
            inst_got_q <= inst_got_d;
            opcode_q   <= opcode_d;
            addr_q     <= addr_d;
            byte_cnt_q <= byte_cnt_d;
            lat_q      <= lat_d;
            is_wr_q    <= is_wr_d;
            is_mr_q    <= is_mr_d;
            mwr_done_q <= mwr_done_d;
            mr_q       <= mr_d;
            io_out_q   <= io_out_d;
            io_en_q    <= io_en_d;
            dqs_out_q  <= dqs_out_d;
            dqs_en_q   <= dqs_en_d;
        end
    end

    // Array is not reset; its contents are undefined after rst_i.
    always_ff @(posedge clk_i) begin
        if (mem_we_c) begin
            mem[addr_q] <= io_q;
        end
    end

    assign psram_io_out_o  = io_out_q;
    assign psram_io_en_o   = io_en_q;
    assign psram_dqs_out_o = dqs_out_q;
    assign psram_dqs_en_o  = dqs_en_q;
    assign mr_o            = mr_q;

`ifdef PSRAM_RSP_CHK_EN
    logic       ce_prev_q, ce_fall_c, unknown_c;
    logic [1:0] guard_q, guard_d;
    logic       err_q, err_d;

    assign ce_fall_c = ce_prev_q & ~ce_q;
    assign unknown_c = (state_q == ADDR) && !ce_q && edge_c && (byte_cnt_q == 2'd3) &&
                       (opcode_q != cfg_rcmd_i) && (opcode_q != cfg_wcmd_i) &&
                       (opcode_q != cfg_mrcmd_i) && (opcode_q != cfg_mwcmd_i);

    // guard_q covers the two clk_i cycles following a ce fall.
    always_comb begin
        guard_d = guard_q;
        if (ce_fall_c) begin
            guard_d = 2'd2;
        end else if (guard_q != 2'd0) begin
            guard_d = guard_q - 2'd1;
        end
        err_d = err_q;
        if (unknown_c) begin
            err_d = 1'b1;
        end
        if (ce_q && (state_q == INST || state_q == ADDR || state_q == LATN)) begin
            err_d = 1'b1;
        end
        if (edge_c && !ce_q && (ce_fall_c || guard_q != 2'd0)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ce_prev_q <= 1'b0;
            guard_q   <= 2'd0;
            err_q     <= 1'b0;
        end else begin
            ce_prev_q <= ce_q;
            guard_q   <= guard_d;
            err_q     <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_psram_rsp.sv
// Bench for psram_rsp: directed protocol scenarios and randomized transfers checked
// against a byte-array / mode-register reference model.
`timescale 1ns/1ps
module tb_psram_rsp;

    localparam int unsigned PH = 4;
    localparam logic [7:0] OP_RD  = 8'h20;
    localparam logic [7:0] OP_WR  = 8'hA0;
    localparam logic [7:0] OP_MRD = 8'h40;
    localparam logic [7:0] OP_MWR = 8'hC0;
    localparam int K_RD = 0, K_WR = 1, K_MRD = 2, K_MWR = 3, K_IGN = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  cfg_rlc, cfg_wlc;
    logic        sck, ce, dqs_in;
    logic [7:0]  io_in;
    logic [7:0]  io_out;
    logic        io_en, dqs_out, dqs_en, err;
    logic [31:0] mr;

    logic [7:0]  mem_m [256];
    logic [7:0]  mr_m  [4];
    logic        err_exp;
    logic [7:0]  dbuf  [256];
    logic        mbuf  [256];
    int          n_tests, n_fail;

    always #5 clk = ~clk;

    psram_rsp #(.MEM_AW(8)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .cfg_rcmd_i     (OP_RD),
        .cfg_wcmd_i     (OP_WR),
        .cfg_mrcmd_i    (OP_MRD),
        .cfg_mwcmd_i    (OP_MWR),
        .cfg_rlc_i      (cfg_rlc),
        .cfg_wlc_i      (cfg_wlc),
        .psram_sck_i    (sck),
        .psram_ce_i     (ce),
        .psram_io_in_i  (io_in),
        .psram_dqs_in_i (dqs_in),
        .psram_io_out_o (io_out),
        .psram_io_en_o  (io_en),
        .psram_dqs_out_o(dqs_out),
        .psram_dqs_en_o (dqs_en),
        .mr_o           (mr),
        .err_o          (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tog(input logic [7:0] d, input logic m);
        sck    = ~sck;
        io_in  = d;
        dqs_in = m;
        wclk(PH);
    endtask

    task automatic close_and_check();
        ce = 1'b1;
        wclk(3);
        check("idle_oe", 32'({io_en, dqs_en}), 32'd0);
        sck    = 1'b0;
        io_in  = 8'd0;
        dqs_in = 1'b0;
        wclk(3);
        check("mr_o", mr, {mr_m[3], mr_m[2], mr_m[1], mr_m[0]});
        check("err_o", 32'(err), 32'(err_exp));
    endtask

    // abort: 0 = full transfer, 1 = ce high after two address bytes, 2 = reset after two data bytes
    task automatic xfer(input logic [7:0] op, input logic [31:0] addr, input int kind,
                        input int n, input int abort);
        int lat;
        logic [7:0] exp;
        ce = 1'b0;
        wclk(4);
        tog(op, 1'b0);
        tog(8'h00, 1'b0);
        for (int b = 3; b >= 0; b--) begin
            tog(addr[8*b +: 8], 1'b0);
            if (abort == 1 && b == 2) begin
                ce = 1'b1;
                wclk(2);
                check("abort_oe", 32'({io_en, dqs_en}), 32'd0);
`ifdef PSRAM_RSP_CHK_EN
                err_exp = 1'b1;
`endif
                close_and_check();
                return;
            end
        end
        if (kind == K_RD || kind == K_MRD || kind == K_WR) begin
            lat = (kind == K_WR) ? int'(cfg_wlc) : int'(cfg_rlc);
            for (int r = 0; r <= lat; r++) begin
                tog(8'h00, 1'b0);
                if (r < lat) tog(8'h00, 1'b0);
            end
        end
        for (int i = 0; i < n; i++) begin
            if (abort == 2 && i == 2) begin
                rst = 1'b1;
                wclk(1);
                check("rst_oe", 32'({io_en, dqs_en}), 32'd0);
                check("rst_io", 32'({io_out, dqs_out}), 32'd0);
                check("rst_mr", mr, 32'd0);
                check("rst_err", 32'(err), 32'd0);
                rst = 1'b0;
                for (int k = 0; k < 4; k++) mr_m[k] = 8'd0;
                err_exp = 1'b0;
                wclk(2);
                for (int k = 0; k < 4; k++) tog(8'h00, 1'b0);
                check("no_reentry", 32'({io_en, dqs_en}), 32'd0);
                close_and_check();
                return;
            end
            if (kind == K_RD || kind == K_MRD) begin
                exp = (kind == K_RD) ? mem_m[(int'(addr[7:0]) + i) % 256]
                                     : mr_m[(int'(addr[1:0]) + i) % 4];
                check("rd_data", 32'(io_out), 32'(exp));
                check("rd_dqs", 32'(dqs_out), 32'(i % 2));
                check("rd_oe", 32'({io_en, dqs_en}), 32'd3);
                tog(8'h00, 1'b0);
            end else begin
                tog(dbuf[i], mbuf[i]);
                if (kind == K_WR && mbuf[i]) mem_m[(int'(addr[7:0]) + i) % 256] = dbuf[i];
                if (kind == K_MWR && i == 0) mr_m[addr[1:0]] = dbuf[0];
                check("no_drive", 32'(io_en), 32'd0);
            end
        end
        close_and_check();
    endtask

    initial begin
        int kind, n;
        logic [31:0] a;
        logic [7:0] op;
        n_tests = 0;
        n_fail  = 0;
        err_exp = 1'b0;
        rst = 1'b1; ce = 1'b1; sck = 1'b0; io_in = 8'd0; dqs_in = 1'b0;
        cfg_rlc = 8'd2; cfg_wlc = 8'd2;
        for (int k = 0; k < 4; k++) mr_m[k] = 8'd0;
        wclk(3);
        check("reset_io", 32'({io_out, dqs_out}), 32'd0);
        check("reset_oe", 32'({io_en, dqs_en}), 32'd0);
        check("reset_mr", mr, 32'd0);
        check("reset_err", 32'(err), 32'd0);
        rst = 1'b0;
        wclk(3);

        // initialize the whole array so every later read has a known expectation
        for (int i = 0; i < 256; i++) begin dbuf[i] = 8'($urandom); mbuf[i] = 1'b1; end
        xfer(OP_WR, 32'h0, K_WR, 256, 0);
        xfer(OP_RD, 32'h80, K_RD, 16, 0);

        for (int i = 0; i < 8; i++) begin dbuf[i] = 8'h11 + 8'(i); mbuf[i] = 1'b1; end
        xfer(OP_WR, 32'h10, K_WR, 8, 0);
        xfer(OP_RD, 32'h10, K_RD, 8, 0);

        dbuf[0] = 8'hFF; dbuf[1] = 8'hFF; mbuf[0] = 1'b1; mbuf[1] = 1'b1;
        xfer(OP_WR, 32'h20, K_WR, 2, 0);
        dbuf[0] = 8'h55; dbuf[1] = 8'h66; mbuf[0] = 1'b1; mbuf[1] = 1'b0;
        xfer(OP_WR, 32'h20, K_WR, 2, 0);
        xfer(OP_RD, 32'h20, K_RD, 2, 0);

        for (int i = 0; i < 4; i++) begin dbuf[i] = 8'($urandom); mbuf[i] = 1'b1; end
        xfer(OP_WR, 32'hABCD_00FE, K_WR, 4, 0);
        cfg_rlc = 8'd0;
        xfer(OP_RD, 32'h0000_00FE, K_RD, 4, 0);
        cfg_rlc = 8'd2;

        dbuf[0] = 8'h3C; dbuf[1] = 8'h5A; dbuf[2] = 8'h77;
        xfer(OP_MWR, 32'h2, K_MWR, 3, 0);
        check("mr_lit", mr, 32'h003C_0000);
        xfer(OP_MRD, 32'h2, K_MRD, 1, 0);
        xfer(OP_MRD, 32'h0, K_MRD, 6, 0);

`ifdef PSRAM_RSP_CHK_EN
        err_exp = 1'b1;
`endif
        for (int i = 0; i < 4; i++) begin dbuf[i] = 8'($urandom); mbuf[i] = 1'b1; end
        xfer(8'h99, 32'h30, K_IGN, 4, 0);
        xfer(OP_RD, 32'h10, K_RD, 4, 0);

        for (int t = 0; t < 24; t++) begin
            kind = $urandom_range(3, 0);
            n    = $urandom_range(8, 1);
            a    = $urandom;
            cfg_rlc = 8'($urandom_range(3, 0));
            cfg_wlc = 8'($urandom_range(3, 0));
            for (int i = 0; i < n; i++) begin
                dbuf[i] = 8'($urandom);
                mbuf[i] = 1'($urandom_range(1, 0));
            end
            case (kind)
                K_RD:    op = OP_RD;
                K_WR:    op = OP_WR;
                K_MRD:   op = OP_MRD;
                default: op = OP_MWR;
            endcase
            xfer(op, a, kind, n, 0);
        end
        cfg_rlc = 8'd2;
        cfg_wlc = 8'd2;

        xfer(OP_RD, 32'h10, K_RD, 4, 1);
        xfer(OP_RD, 32'h10, K_RD, 4, 0);

        xfer(OP_RD, 32'h40, K_RD, 6, 2);
        for (int i = 0; i < 8; i++) begin dbuf[i] = 8'($urandom); mbuf[i] = 1'b1; end
        xfer(OP_WR, 32'h40, K_WR, 8, 0);
        xfer(OP_RD, 32'h40, K_RD, 8, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/psram_rsp.md
PSRAM_RSP -- requirements
Module: psram_rsp

Interface
REQ-001 SHALL have parameter MEM_AW, default 8, byte-address width of internal array (2**MEM_AW bytes).
REQ-002 SHALL have port clk_i  in  1  core clock, at least 4x psram_sck_i frequency, same clock domain as the initiator.
REQ-003 SHALL have port rst_i  in  1  reset, asynchronous and active-high.
REQ-004 SHALL have ports cfg_rcmd_i, cfg_wcmd_i, cfg_mrcmd_i, cfg_mwcmd_i  in  8 each  opcodes for array read, array write, mode-register read, mode-register write.
REQ-005 SHALL have ports cfg_rlc_i, cfg_wlc_i  in  8 each  read/write latency in sck cycles.
REQ-006 SHALL have ports psram_sck_i (in, 1, serial clock), psram_ce_i (in, 1, chip enable, active-low), psram_io_in_i (in, 8, octal data from initiator) and psram_dqs_in_i (in, 1, write byte mask, 1 = byte written).
REQ-007 SHALL have ports psram_io_out_o (out, 8, read data), psram_io_en_o (out, 1, io drive enable, 1 = responder drives), psram_dqs_out_o (out, 1, read strobe) and psram_dqs_en_o (out, 1, strobe drive enable).
REQ-008 SHALL have ports mr_o (out, 32, mode registers MR3..MR0 concatenated) and err_o (out, 1, sticky protocol error).

Function
REQ-009 SHALL register sck, ce, io_in and dqs_in once; an edge is a change of registered sck versus its previous value; all captures use the registered io/dqs.
REQ-010 SHALL implement states IDLE, INST, ADDR, LATN, WDATA, RDATA, MWR, IGNR.
REQ-011 Registered ce low in IDLE SHALL enter INST; registered ce high in any state SHALL return to IDLE the next cycle and release io/dqs drive.
REQ-012 INST SHALL latch the opcode on the first rising edge, ignore the following falling edge, then enter ADDR.
REQ-013 ADDR SHALL shift in 4 bytes MSB first, one per edge, forming a 32-bit address; bits above MEM_AW are ignored.
REQ-014 After the 4th address byte: rcmd/mrcmd -> LATN with count cfg_rlc_i; wcmd -> LATN with count cfg_wlc_i; mwcmd -> MWR; any other opcode -> IGNR.
REQ-015 LATN SHALL decrement on each rising edge and leave for RDATA/WDATA on the rising edge where count is 0 (latency 0 = data starts on next edge).
REQ-016 WDATA SHALL capture one byte per edge into array[addr] only if dqs was 1, then increment addr modulo 2**MEM_AW.
REQ-017 RDATA SHALL present array[addr] (mrcmd: MR[addr[1:0]]) on psram_io_out_o within 1 clk_i of entering, and update to the next byte within 1 clk_i after each sck edge, address incrementing and wrapping.
REQ-018 RDATA SHALL drive psram_dqs_out_o toggling once per byte, starting at 0, with psram_io_en_o and psram_dqs_en_o both 1 only in RDATA.
REQ-019 MWR SHALL write the first data byte to MR[addr[1:0]], ignore further bytes until ce high; MR writes ignore dqs.
REQ-020 IGNR SHALL ignore all edges until ce high.
REQ-021 A write and a read to the same byte never overlap (single port); reads after a completed write return the new value.

Reset
REQ-022 On rst_i: state IDLE, io_out 0, io_en 0, dqs_out 0, dqs_en 0, mr_o 0, err_o 0, address 0; array contents undefined; reset mid-transaction abandons it and requires ce high before the next INST.

Configuration
REQ-023 Macro PSRAM_RSP_CHK_EN defined: err_o sets and holds (until reset) on unknown opcode, or ce rising in INST/ADDR/LATN, or a sck edge within 2 clk_i of ce falling.
REQ-024 Macro PSRAM_RSP_CHK_EN undefined: err_o tied 0, no checker logic; all other behaviour identical.

Verification
REQ-025 Write opcode 0xA0, addr 0x10, wlc 2, bytes 0x11..0x18, dqs all 1; read opcode 0x20, rlc 2 -> io returns 0x11..0x18, dqs toggles 8 times.
REQ-026 Write 0x55,0x66 to 0x20 with dqs 1,0 over prior 0xFF,0xFF -> read returns 0x55,0xFF.
REQ-027 MEM_AW 8, read 4 bytes from 0xFE -> array[0xFE],[0xFF],[0x00],[0x01].
REQ-028 mwcmd 0xC0, addr 2, data 0x3C -> mr_o = 0x003C0000; mrcmd 0x40 addr 2 -> returns 0x3C.
REQ-029 Opcode 0x99 with PSRAM_RSP_CHK_EN -> err_o 1 stays 1, no drive; next valid read succeeds; without macro err_o stays 0.
REQ-030 ce raised after 2 address bytes, or rst_i pulsed mid-read -> IDLE, io_en 0 within 2 clk_i; following full transaction correct.
